reg_file: RTL and testbench

- General-purpose integer register file for the processor datapath: 32 registers x 32 bits, two asynchronous read ports (rs1, rs2), one synchronous write port (rd).
- Sits between decode and execute. Operand addresses come from the instruction fields; write-back data comes from the WB stage.
- Register 0 is hardwired to zero (RISC-V x0 semantics).

---
 rtl/reg_file.sv | 87 ++++++++
 tb/tb_reg_file.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit integer register file with two combinational read
// ports (rs1/rOut1, rs2/rOut2) and one synchronous write port (rd/wr/Din).
// Register 0 is hardwired to zero and has no storage behind it.
// Optional build macro: REGFILE_BYPASS_EN enables write-through forwarding
// of Din onto a read port that addresses the register being written.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] Din,
    output logic [DATA_WIDTH-1:0] rOut1,
    output logic [DATA_WIDTH-1:0] rOut2,
    input  logic                  CLK,
    input  logic                  reset
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    // Only registers 1..NUM_REGS-1 are stored; x0 reads as a constant.
    logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

    // A write to rd=0 matches no stored entry, so it is dropped here.
    logic write_en;
    assign write_en = wr && (rd != '0);

    // Next-state: hold every register, except the one addressed by an enabled write.
    always_comb begin
        // NOTE: every register gets its current value first, so no path leaves regs_d unassigned and no latch is inferred.
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            if (write_en && (rd == ADDR_WIDTH'(i))) begin
                regs_d[i] = Din;
            end
        end
    end

    // State register: synchronous clear has priority over any write in the same cycle.
    always_ff @(posedge CLK) begin
        if (reset) begin
            // NOTE: this array is cleared on reset because x1..x31 must read zero after reset; plain RAM arrays normally stay unreset.
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignment so every register samples regs_d from before the edge, independent of statement order.
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Returns stored contents; address 0 always reads as zero.
    function automatic logic [DATA_WIDTH-1:0] read_stored(input logic [ADDR_WIDTH-1:0] addr);
        if (addr == '0) begin
            return '0;
        end
        return regs_q[addr];
    endfunction

`ifdef REGFILE_BYPASS_EN
    // Read ports with write-through forwarding of the in-flight write-back data.
    always_comb begin
        rOut1 = read_stored(rs1);
        rOut2 = read_stored(rs2);
        if (write_en && !reset && (rs1 == rd)) begin
            rOut1 = Din;
        end
        if (write_en && !reset && (rs2 == rd)) begin
            rOut2 = Din;
        end
    end
`else
    // Read ports return stored contents only; a same-cycle write shows after the edge.
    always_comb begin
        rOut1 = read_stored(rs1);
        rOut2 = read_stored(rs2);
    end
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed, self-checking bench for reg_file.
// Expected values are hand-computed constants; build with +define+REGFILE_BYPASS_EN
// to check the forwarding variant of the same-cycle read-after-write case.
module tb_reg_file;

    localparam int DW = 32;
    localparam int AW = 5;

    logic [AW-1:0] rs1, rs2, rd;
    logic          wr;
    logic [DW-1:0] Din;
    logic [DW-1:0] rOut1, rOut2;
    logic          CLK;
    logic          reset;

    int n_cmp = 0;
    int n_mis = 0;

    reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .rs1   (rs1),
        .rs2   (rs2),
        .rd    (rd),
        .wr    (wr),
        .Din   (Din),
        .rOut1 (rOut1),
        .rOut2 (rOut2),
        .CLK   (CLK),
        .reset (reset)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wr  = 1'b1;
        rd  = addr;
        Din = data;
        tick();
        wr  = 1'b0;
    endtask

    logic [AW-1:0] waddr [8] = '{5'd4, 5'd5, 5'd8, 5'd9, 5'd18, 5'd22, 5'd25, 5'd31};
    logic [DW-1:0] wdata [8] = '{32'd11111, 32'd3, 32'd121, 32'd28, 32'd1000, 32'd1190, 32'd267, 32'd1728};

    initial begin
        // Reset with all other inputs driven to known values.
        reset = 1'b1;
        wr    = 1'b0;
        rd    = '0;
        Din   = '0;
        rs1   = '0;
        rs2   = '0;
        tick();
        reset = 1'b0;

        // Reset then read: every address reads zero on both ports.
        for (int i = 0; i < 32; i++) begin
            rs1 = AW'(i);
            rs2 = AW'(31 - i);
            #1;
            check($sformatf("reset_rd1_r%0d", i), rOut1, 32'd0);
            check($sformatf("reset_rd2_r%0d", 31 - i), rOut2, 32'd0);
        end

        // Basic write/read.
        write_reg(5'd1, 32'd39);
        write_reg(5'd2, 32'd47);
        rs1 = 5'd1;
        rs2 = 5'd2;
        #1;
        check("basic_r1", rOut1, 32'd39);
        check("basic_r2", rOut2, 32'd47);

        // Multiple registers, read in pairs.
        for (int i = 0; i < 8; i++) begin
            write_reg(waddr[i], wdata[i]);
        end
        for (int i = 0; i < 8; i += 2) begin
            rs1 = waddr[i];
            rs2 = waddr[i + 1];
            #1;
            check($sformatf("multi_r%0d", waddr[i]), rOut1, wdata[i]);
            check($sformatf("multi_r%0d", waddr[i + 1]), rOut2, wdata[i + 1]);
        end
        rs1 = 5'd1;
        rs2 = 5'd2;
        #1;
        check("multi_keep_r1", rOut1, 32'd39);
        check("multi_keep_r2", rOut2, 32'd47);

        // Both ports on the same register.
        rs1 = 5'd31;
        rs2 = 5'd31;
        #1;
        check("same_port1_r31", rOut1, 32'd1728);
        check("same_port2_r31", rOut2, 32'd1728);

        // wr=0 must not write.
        wr  = 1'b0;
        rd  = 5'd4;
        Din = 32'd999;
        tick();
        rs1 = 5'd4;
        #1;
        check("wr0_r4_kept", rOut1, 32'd11111);

        // Write to x0 is ignored, including before the edge.
        wr  = 1'b1;
        rd  = 5'd0;
        Din = 32'd55;
        rs1 = 5'd0;
        rs2 = 5'd0;
        #1;
        check("x0_before_edge", rOut1, 32'd0);
        tick();
        wr = 1'b0;
        #1;
        check("x0_after_p1", rOut1, 32'd0);
        check("x0_after_p2", rOut2, 32'd0);

        // Reset priority over a simultaneous write.
        reset = 1'b1;
        wr    = 1'b1;
        rd    = 5'd3;
        Din   = 32'd77;
        tick();
        reset = 1'b0;
        wr    = 1'b0;
        rs1   = 5'd3;
        rs2   = 5'd31;
        #1;
        check("rstprio_r3", rOut1, 32'd0);
        check("rstprio_r31", rOut2, 32'd0);
        rs1 = 5'd1;
        rs2 = 5'd4;
        #1;
        check("rstprio_r1", rOut1, 32'd0);
        check("rstprio_r4", rOut2, 32'd0);

        // Same-cycle read-after-write on r6.
        write_reg(5'd6, 32'd10);
        wr  = 1'b1;
        rd  = 5'd6;
        Din = 32'd20;
        rs1 = 5'd6;
        rs2 = 5'd6;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("raw_before_p1", rOut1, 32'd20);
        check("raw_before_p2", rOut2, 32'd20);
`else
        check("raw_before_p1", rOut1, 32'd10);
        check("raw_before_p2", rOut2, 32'd10);
`endif
        tick();
        wr = 1'b0;
        #1;
        check("raw_after_p1", rOut1, 32'd20);
        check("raw_after_p2", rOut2, 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
